// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between a requester and the memory responder.
interface memory_responder_if;

  logic        request_valid;
  logic        request_write;
  logic [31:0] read_memory_address;
  logic [31:0] write_memory_address;
  logic [31:0] write_memory_data;
  logic [31:0] write_memory_mask;
  logic [31:0] read_memory_data;
  logic        busy;
  logic        done;
  logic        fault;

  modport master (
    output request_valid, request_write, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    input  read_memory_data, busy, done, fault
  );

  modport slave (
    input  request_valid, request_write, read_memory_address,
           write_memory_address, write_memory_data, write_memory_mask,
    output read_memory_data, busy, done, fault
  );

endinterface

// File: rtl/ram_word_masked.sv
// Word storage with a bit-masked synchronous write and an asynchronous read.
// Contents are deliberately not reset.
module ram_word_masked #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [31:0]   i_wmask,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding memory responder: optional write-then-read against a
// masked word RAM, with programmable stall cycles and range fault reporting.
module memory_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH        = 4096,
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          WAIT_CYCLES  = 0
) (
  input  logic               clk,
  input  logic               reset,
  memory_responder_if.slave  bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [33:0] SPAN     = 34'(WORD_BYTES * DEPTH);
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        w_enter_done;

  logic        r_write;
  logic [31:0] r_rd_addr, r_wr_addr, r_wdata, r_wmask;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic        w_accept, w_write;
  logic [31:0] w_rd_addr, w_wr_addr, w_wdata, w_wmask;
  logic [33:0] w_rd_off, w_wr_off;
  logic        w_rd_ok, w_wr_ok, w_we;
  logic [AW-1:0] w_rd_idx, w_wr_idx;
  logic [31:0] w_ram_rdata, w_rdata_next;

  assign w_accept = (r_state == IDLE) && bus.request_valid;

  // In IDLE the live inputs drive the datapath so a zero-wait access can
  // complete on its own acceptance edge; afterwards the captured copies do.
  assign w_write   = (r_state == IDLE) ? bus.request_write        : r_write;
  assign w_rd_addr = (r_state == IDLE) ? bus.read_memory_address  : r_rd_addr;
  assign w_wr_addr = (r_state == IDLE) ? bus.write_memory_address : r_wr_addr;
  assign w_wdata   = (r_state == IDLE) ? bus.write_memory_data    : r_wdata;
  assign w_wmask   = (r_state == IDLE) ? bus.write_memory_mask    : r_wmask;

  // Widened subtraction: an address below the base sets bit 33 instead of wrapping.
  assign w_rd_off = {2'b00, w_rd_addr} - {2'b00, BASE_ADDRESS};
  assign w_wr_off = {2'b00, w_wr_addr} - {2'b00, BASE_ADDRESS};
  assign w_rd_ok  = !w_rd_off[33] && (w_rd_off < SPAN);
  assign w_wr_ok  = !w_wr_off[33] && (w_wr_off < SPAN);
  assign w_rd_idx = w_rd_off[AW+1:2];
  assign w_wr_idx = w_wr_off[AW+1:2];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_enter_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.request_valid) begin
          w_cnt_next = 4'd0;
          if (WAIT_LIM == 4'd0) begin
            w_state_next = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt + 4'd1;
        if (w_cnt_next == WAIT_LIM) begin
          w_state_next = DONE;
          w_enter_done = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_we = reset && w_enter_done && w_write && w_wr_ok;

  ram_word_masked #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_idx),
    .i_wdata (w_wdata),
    .i_wmask (w_wmask),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_rdata)
  );

  // The store lands on the same edge as the read capture, so merge it in here.
  always_comb begin
    w_rdata_next = 32'h0;
    if (w_rd_ok) begin
      if (w_write && w_wr_ok && (w_rd_idx == w_wr_idx)) begin
        w_rdata_next = (w_ram_rdata & ~w_wmask) | (w_wdata & w_wmask);
      end else begin
        w_rdata_next = w_ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_enter_done) begin
        r_rdata <= w_rdata_next;
        r_fault <= !w_rd_ok || (w_write && !w_wr_ok);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write   <= bus.request_write;
      r_rd_addr <= bus.read_memory_address;
      r_wr_addr <= bus.write_memory_address;
      r_wdata   <= bus.write_memory_data;
      r_wmask   <= bus.write_memory_mask;
    end
  end

  assign bus.busy             = (r_state != IDLE);
  assign bus.done             = (r_state == DONE);
  assign bus.fault            = r_fault;
  assign bus.read_memory_data = r_rdata;

endmodule

// File: tb/tb_memory_responder.sv
// Three responder configurations checked against an address-map reference model.
module tb_memory_responder;

  function automatic int cfg_depth(input int i);
    return (i == 1) ? 64 : 16;
  endfunction

  function automatic logic [31:0] cfg_base(input int i);
    return (i == 1) ? 32'h100 : 32'h0;
  endfunction

  function automatic int cfg_wait(input int i);
    return (i == 1) ? 3 : ((i == 2) ? 2 : 0);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  rv, rw;
  logic [31:0] ra [3];
  logic [31:0] wa [3];
  logic [31:0] wd [3];
  logic [31:0] wm [3];
  logic [31:0] rdo [3];
  logic [2:0]  busy_o, done_o, fault_o;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      memory_responder_if bus ();
      assign bus.request_valid        = rv[gi];
      assign bus.request_write        = rw[gi];
      assign bus.read_memory_address  = ra[gi];
      assign bus.write_memory_address = wa[gi];
      assign bus.write_memory_data    = wd[gi];
      assign bus.write_memory_mask    = wm[gi];
      assign rdo[gi]     = bus.read_memory_data;
      assign busy_o[gi]  = bus.busy;
      assign done_o[gi]  = bus.done;
      assign fault_o[gi] = bus.fault;

      memory_responder #(
        .DEPTH        (cfg_depth(gi)),
        .BASE_ADDRESS (cfg_base(gi)),
        .WAIT_CYCLES  (cfg_wait(gi))
      ) dut (
        .clk   (clk),
        .reset (rst_n[gi]),
        .bus   (bus)
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl   [3][64];
  bit          known [3][64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit in_map(input int d, input logic [31:0] a);
    longint lo, hi, al;
    lo = longint'({32'h0, cfg_base(d)});
    hi = lo + 4 * cfg_depth(d);
    al = longint'({32'h0, a});
    return (al >= lo) && (al < hi);
  endfunction

  function automatic int word_of(input int d, input logic [31:0] a);
    return int'((longint'({32'h0, a}) - longint'({32'h0, cfg_base(d)})) >> 2);
  endfunction

  // Reference: apply the write (if any) then predict the read result and fault.
  task automatic model_apply(input int d, input bit wr, input logic [31:0] raddr,
                             input logic [31:0] waddr, input logic [31:0] data,
                             input logic [31:0] mask, output logic [31:0] exp_rd,
                             output bit exp_known, output bit exp_fault);
    int w, r;
    if (wr && in_map(d, waddr)) begin
      w = word_of(d, waddr);
      if (known[d][w]) begin
        mdl[d][w] = (mdl[d][w] & ~mask) | (data & mask);
      end else if (mask == 32'hFFFF_FFFF) begin
        mdl[d][w]   = data;
        known[d][w] = 1'b1;
      end
    end
    exp_rd    = 32'h0;
    exp_known = 1'b1;
    if (in_map(d, raddr)) begin
      r         = word_of(d, raddr);
      exp_known = known[d][r];
      exp_rd    = mdl[d][r];
    end
    exp_fault = !in_map(d, raddr) || (wr && !in_map(d, waddr));
  endtask

  task automatic drive(input int d, input bit wr, input logic [31:0] raddr,
                       input logic [31:0] waddr, input logic [31:0] data,
                       input logic [31:0] mask);
    @(negedge clk);
    rv[d] = 1'b1;
    rw[d] = wr;
    ra[d] = raddr;
    wa[d] = waddr;
    wd[d] = data;
    wm[d] = mask;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int d, input bit keep_valid);
    rv[d] = keep_valid;
    rw[d] = 1'($urandom);
    ra[d] = $urandom;
    wa[d] = $urandom;
    wd[d] = $urandom;
    wm[d] = $urandom;
  endtask

  task automatic txn(input int d, input bit wr, input logic [31:0] raddr,
                     input logic [31:0] waddr, input logic [31:0] data,
                     input logic [31:0] mask, input bit pulse);
    logic [31:0] exp_rd;
    bit exp_known, exp_fault;
    int lat;
    model_apply(d, wr, raddr, waddr, data, mask, exp_rd, exp_known, exp_fault);
    drive(d, wr, raddr, waddr, data, mask);
    scramble(d, pulse);
    lat = 1;
    while (!done_o[d] && lat <= 20) begin
      chk($sformatf("busy_in_wait d%0d", d), {31'h0, busy_o[d]}, 32'h1);
      @(posedge clk);
      #1;
      rv[d] = 1'b0;
      lat++;
    end
    chk($sformatf("latency d%0d", d), lat, cfg_wait(d) + 1);
    chk($sformatf("done d%0d", d), {31'h0, done_o[d]}, 32'h1);
    chk($sformatf("busy_at_done d%0d", d), {31'h0, busy_o[d]}, 32'h1);
    chk($sformatf("fault d%0d", d), {31'h0, fault_o[d]}, {31'h0, exp_fault});
    if (exp_known) chk($sformatf("rdata d%0d", d), rdo[d], exp_rd);
    $display("txn d%0d wr=%0b raddr=%08h waddr=%08h data=%08h mask=%08h -> rdata=%08h fault=%0b lat=%0d",
             d, wr, raddr, waddr, data, mask, rdo[d], fault_o[d], lat);
    @(posedge clk);
    #1;
    rv[d] = 1'b0;
    chk($sformatf("done_drop d%0d", d), {31'h0, done_o[d]}, 32'h0);
    chk($sformatf("idle_busy d%0d", d), {31'h0, busy_o[d]}, 32'h0);
    if (pulse) begin
      @(posedge clk);
      #1;
      chk($sformatf("no_queue d%0d", d), {30'h0, done_o[d], busy_o[d]}, 32'h0);
    end
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int sel;
    logic [31:0] base;
    base = cfg_base(d);
    sel  = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFC;
    if (sel == 1) return (base == 32'h0) ? 32'hFFFF_FFF0 : base - 32'h4;
    if (sel == 2) return base + 32'(4 * cfg_depth(d)) + 32'($urandom_range(0, 15));
    return base + 32'($urandom_range(0, 4 * cfg_depth(d) - 1));
  endfunction

  initial begin
    logic [31:0] exp_rd, a_r, a_w, m;
    bit exp_known, exp_fault;

    rst_n = 3'b000;
    rv    = 3'b000;
    rw    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ra[i] = 32'h0; wa[i] = 32'h0; wd[i] = 32'h0; wm[i] = 32'h0;
      for (int j = 0; j < 64; j++) begin
        mdl[i][j]   = 32'h0;
        known[i][j] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy d%0d", i), {31'h0, busy_o[i]}, 32'h0);
      chk($sformatf("reset_done d%0d", i), {31'h0, done_o[i]}, 32'h0);
      chk($sformatf("reset_fault d%0d", i), {31'h0, fault_o[i]}, 32'h0);
      chk($sformatf("reset_rdata d%0d", i), rdo[i], 32'h0);
    end
    $display("reset released");
    rst_n = 3'b111;

    // Zero-wait instance: read after write, byte lanes, same-word forwarding.
    txn(0, 1'b1, 32'h10, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h0C, 32'h10, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0);
    txn(0, 1'b1, 32'h0C, 32'h10, 32'hAA00_0000, 32'hFF00_0000, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("byte_lane_model", mdl[0][4], 32'hAA22_3344);
    txn(0, 1'b1, 32'h20, 32'h20, 32'h5, 32'hFFFF_FFFF, 1'b0);
    txn(0, 1'b1, 32'h10, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1);

    // Out of range at the top of a 16-word map; word 0 must survive.
    txn(0, 1'b1, 32'h0, 32'h0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0);
    txn(0, 1'b1, 32'h40, 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    txn(0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h0, 32'h40, 32'h0, 32'hFFFF_FFFF, 1'b0);

    // Three-wait instance with a non-zero base; extra request while busy.
    txn(1, 1'b1, 32'h110, 32'h110, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0);
    txn(1, 1'b0, 32'h110, 32'h0, 32'h0, 32'h0, 1'b1);
    txn(1, 1'b0, 32'hFC, 32'h0, 32'h0, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h1FC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset during DONE keeps the committed write.
    model_apply(0, 1'b1, 32'h8, 32'h8, 32'h5A5A_0101, 32'hFFFF_FFFF, exp_rd, exp_known, exp_fault);
    drive(0, 1'b1, 32'h8, 32'h8, 32'h5A5A_0101, 32'hFFFF_FFFF);
    scramble(0, 1'b0);
    chk("rst_done_state", {31'h0, done_o[0]}, 32'h1);
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_done_busy", {31'h0, busy_o[0]}, 32'h0);
    chk("rst_done_rdata", rdo[0], 32'h0);
    $display("reset applied in DONE on d0");
    rst_n[0] = 1'b1;
    txn(0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset during WAIT aborts the write.
    txn(2, 1'b1, 32'h14, 32'h14, 32'h7777_8888, 32'hFFFF_FFFF, 1'b0);
    drive(2, 1'b1, 32'h14, 32'h14, 32'h0000_1111, 32'hFFFF_FFFF);
    scramble(2, 1'b0);
    chk("rst_wait_busy_before", {31'h0, busy_o[2]}, 32'h1);
    rst_n[2] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wait_busy", {31'h0, busy_o[2]}, 32'h0);
    chk("rst_wait_fault", {31'h0, fault_o[2]}, 32'h0);
    chk("rst_wait_rdata", rdo[2], 32'h0);
    rst_n[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_wait_no_done", {31'h0, done_o[2]}, 32'h0);
      @(posedge clk);
      #1;
    end
    $display("reset applied in WAIT on d2");
    txn(2, 1'b0, 32'h14, 32'h0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        a_r = rand_addr(d);
        a_w = rand_addr(d);
        m   = ($urandom_range(0, 2) == 0) ? $urandom : 32'hFFFF_FFFF;
        txn(d, 1'($urandom), a_r, a_w, $urandom, m, 1'($urandom_range(0, 3) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
